stepper_step_gen: RTL

Command-driven step/direction pulse generator for one stepper axis of the drawing robot. It sits directly downstream of the processor's memory-mapped I/O decode. It accepts a move command (step count, direction, step half-period) over a valid/ready handshake and emits the exact number of STEP pulses with a guarded DIR setup time. It reports busy, completion and remaining steps back to software.

---
 rtl/stepper_step_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stepper_step_gen.sv
// rtl/stepper_step_gen.sv - step/direction pulse generator for one stepper axis
module stepper_step_gen #(
    parameter int STEPS_W          = 16,
    parameter int PERIOD_W         = 24,
    parameter int DIR_SETUP_CYCLES = 100,
    parameter int MIN_HALF_PERIOD  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_half_period,
    input  logic                abort,
    output logic                step_out,
    output logic                dir_out,
    output logic                busy,
    output logic                done,
    output logic [STEPS_W-1:0]  steps_remaining
);

    localparam int SETUP_W = (DIR_SETUP_CYCLES < 1) ? 1 : $clog2(DIR_SETUP_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [PERIOD_W-1:0] H_MIN      = PERIOD_W'(MIN_HALF_PERIOD);
    localparam logic [PERIOD_W-1:0] P_ONE      = PERIOD_W'(1);
    localparam logic [STEPS_W-1:0]  S_ONE      = STEPS_W'(1);
    localparam logic [SETUP_W-1:0]  U_ONE      = SETUP_W'(1);
    localparam logic [SETUP_W-1:0]  SETUP_LAST = SETUP_W'(DIR_SETUP_CYCLES - 1);

    logic [2:0]          state;
    logic [PERIOD_W-1:0] half;
    logic [PERIOD_W-1:0] phase_cnt;
    logic [SETUP_W-1:0]  setup_cnt;
    logic                abort_pend;
    logic [PERIOD_W-1:0] half_clamped;
    logic                accept;
    logic                dir_change;

    assign half_clamped = (cmd_half_period < H_MIN) ? H_MIN : cmd_half_period;
    assign accept       = cmd_valid & cmd_ready;
    assign dir_change   = (cmd_dir != dir_out) && (DIR_SETUP_CYCLES > 0);

    // Phase counters load N-1 so a phase spans exactly N cycles ending on the zero edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            step_out        <= 1'b0;
            dir_out         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cmd_ready       <= 1'b0;
            steps_remaining <= '0;
            half            <= '0;
            phase_cnt       <= '0;
            setup_cnt       <= '0;
            abort_pend      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready       <= 1'b0;
                        steps_remaining <= cmd_steps;
                        half            <= half_clamped;
                        dir_out         <= cmd_dir;
                        abort_pend      <= 1'b0;
                        if (cmd_steps == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (dir_change) begin
                            state     <= S_SETUP;
                            busy      <= 1'b1;
                            setup_cnt <= SETUP_LAST;
                        end else begin
                            state     <= S_HIGH;
                            busy      <= 1'b1;
                            step_out  <= 1'b1;
                            phase_cnt <= half_clamped - P_ONE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (setup_cnt == '0) begin
                        state     <= S_HIGH;
                        step_out  <= 1'b1;
                        phase_cnt <= half - P_ONE;
                    end else begin
                        setup_cnt <= setup_cnt - U_ONE;
                    end
                end
                S_HIGH: begin
                    // An abort seen mid-pulse is remembered so the pulse still completes.
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (phase_cnt == '0) begin
                        step_out        <= 1'b0;
                        steps_remaining <= steps_remaining - S_ONE;
                        if (abort_pend || abort) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_LOW;
                            phase_cnt <= half - P_ONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - P_ONE;
                    end
                end
                S_LOW: begin
                    if (abort || (phase_cnt == '0 && steps_remaining == '0)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (phase_cnt == '0) begin
                        state     <= S_HIGH;
                        step_out  <= 1'b1;
                        phase_cnt <= half - P_ONE;
                    end else begin
                        phase_cnt <= phase_cnt - P_ONE;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    done       <= 1'b0;
                    cmd_ready  <= 1'b1;
                    abort_pend <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    step_out  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
